// File: rtl/softplus_backward_16_bit.sv
// Softplus backward unit: grad_x = grad_y * sigmoid(x), with sigmoid approximated
// piecewise-linearly over 8 segments on [-6, 6); 3-stage valid/ready pipeline.
module softplus_backward_16_bit #(
    parameter int N = 16,
    parameter int Q = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [N-1:0] x,
    input  logic signed [N-1:0] grad_y,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [N-1:0] grad_x,
    output logic        [N-1:0] sig
);

    localparam int FW = 13;   // frac spans 0..6143 within one segment
    localparam int PW = 23;   // slope * frac product width

    typedef enum logic [1:0] {
        RGN_SEG  = 2'd0,
        RGN_LOW  = 2'd1,
        RGN_HIGH = 2'd2
    } region_e;

    function automatic logic signed [N-1:0] bk(input int unsigned i);
        logic signed [N-1:0] r;
        case (i)
            0:       r = -16'sd24576;
            1:       r = -16'sd18432;
            2:       r = -16'sd12288;
            3:       r = -16'sd6144;
            4:       r = 16'sd0;
            5:       r = 16'sd6144;
            6:       r = 16'sd12288;
            7:       r = 16'sd18432;
            default: r = 16'sd24576;
        endcase
        return r;
    endfunction

    function automatic logic [N-1:0] knot(input logic [2:0] i);
        logic [N-1:0] r;
        case (i)
            3'd0:    r = 16'd10;
            3'd1:    r = 16'd45;
            3'd2:    r = 16'd194;
            3'd3:    r = 16'd747;
            3'd4:    r = 16'd2048;
            3'd5:    r = 16'd3349;
            3'd6:    r = 16'd3902;
            default: r = 16'd4051;
        endcase
        return r;
    endfunction

    function automatic logic [PW-1:0] slope(input logic [2:0] i);
        logic [PW-1:0] r;
        case (i)
            3'd0, 3'd7: r = 23'd23;
            3'd1, 3'd6: r = 23'd99;
            3'd2, 3'd5: r = 23'd369;
            default:    r = 23'd867;
        endcase
        return r;
    endfunction

    // Pipeline state
    logic                v1_q, v2_q, v3_q;
    region_e             rgn1_q, rgn1_d;
    logic [2:0]          seg1_q, seg1_d;
    logic [FW-1:0]       frac1_q, frac1_d;
    logic signed [N-1:0] gy1_q;
    logic [N-1:0]        s2_q, s2_d;
    logic signed [N-1:0] gy2_q;
    logic signed [N-1:0] gx3_q, gx3_d;
    logic [N-1:0]        sig3_q;

    logic                stall;
    logic [PW-1:0]       prod2;
    logic signed [2*N-1:0] prod3;

    assign stall     = v3_q & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = v3_q;
    assign grad_x    = gx3_q;
    assign sig       = sig3_q;

    // Stage 1: region and segment select
    always_comb begin
        rgn1_d  = RGN_SEG;
        seg1_d  = '0;
        frac1_d = '0;
        if (x < bk(0)) begin
            rgn1_d = RGN_LOW;
        end else if (x >= bk(8)) begin
            rgn1_d = RGN_HIGH;
        end else begin
            for (int unsigned i = 1; i < 8; i++) begin
                if (x >= bk(i)) seg1_d = 3'(i);
            end
            // Offset is known to fit in FW bits, so modular subtraction is exact.
            frac1_d = FW'(x) - FW'(bk(32'(seg1_d)));
        end
    end

    // Stage 2: sigmoid interpolation
    always_comb begin
        prod2 = slope(seg1_q) * PW'(frac1_q);
        s2_d  = knot(seg1_q) + N'(prod2 >> Q);
        if (rgn1_q == RGN_LOW)  s2_d = '0;
        if (rgn1_q == RGN_HIGH) s2_d = N'(1) << Q;
    end

    // Stage 3: gradient scaling, arithmetic shift floors toward -inf
    always_comb begin
        prod3 = (2*N)'(gy2_q) * (2*N)'($signed({1'b0, s2_q}));
        gx3_d = N'(prod3 >>> Q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            rgn1_q  <= RGN_SEG;
            seg1_q  <= '0;
            frac1_q <= '0;
            gy1_q   <= '0;
            s2_q    <= '0;
            gy2_q   <= '0;
            gx3_q   <= '0;
            sig3_q  <= '0;
        end else if (!stall) begin
            v1_q <= in_valid;
            v2_q <= v1_q;
            v3_q <= v2_q;
            if (in_valid) begin
                rgn1_q  <= rgn1_d;
                seg1_q  <= seg1_d;
                frac1_q <= frac1_d;
                gy1_q   <= grad_y;
            end
            if (v1_q) begin
                s2_q  <= s2_d;
                gy2_q <= gy1_q;
            end
            if (v2_q) begin
                gx3_q  <= gx3_d;
                sig3_q <= s2_q;
            end
        end
    end

endmodule

// File: tb/tb_softplus_backward_16_bit.sv
// Self-checking bench for softplus_backward_16_bit: vector table, random stream,
// backpressure and mid-stream reset, all checked through an expected-result queue.
module tb_softplus_backward_16_bit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x;
    logic [15:0] grad_y;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] grad_x;
    logic [15:0] sig;

    softplus_backward_16_bit #(.N(16), .Q(12)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .grad_y    (grad_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .grad_x    (grad_x),
        .sig       (sig)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] x;
        logic [15:0] gy;
        logic [15:0] sig;
        logic [15:0] gx;
    } vec_t;

    typedef struct {
        logic [15:0] sig;
        logic [15:0] gx;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_out   = 0;
    int   cyc     = 0;
    bit   lat_chk = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] sig_model(input logic [15:0] xv);
        int xi, off, seg, frac, k, m;
        xi = int'($signed(xv));
        if (xi < -24576) return 16'd0;
        if (xi >= 24576) return 16'd4096;
        off  = xi + 24576;
        seg  = off / 6144;
        frac = off % 6144;
        case (seg)
            0: begin k = 10;   m = 23;  end
            1: begin k = 45;   m = 99;  end
            2: begin k = 194;  m = 369; end
            3: begin k = 747;  m = 867; end
            4: begin k = 2048; m = 867; end
            5: begin k = 3349; m = 369; end
            6: begin k = 3902; m = 99;  end
            default: begin k = 4051; m = 23; end
        endcase
        return 16'(k + (m * frac) / 4096);
    endfunction

    function automatic logic [15:0] grad_model(input logic [15:0] gv, input logic [15:0] s);
        longint p, q;
        p = longint'($signed(gv)) * longint'(s);
        if (p < 0) q = -((-p + 4095) / 4096);
        else       q = p / 4096;
        return 16'(q);
    endfunction

    // One cycle: drive at the falling edge, sample/score 1ns later, wait for next falling edge.
    task automatic tick(input logic v, input logic [15:0] xv, input logic [15:0] gv,
                        input logic [15:0] esig, input logic [15:0] egx, input logic ordy,
                        output logic acc, output logic rdy);
        exp_t e;
        in_valid  = v;
        x         = xv;
        grad_y    = gv;
        out_ready = ordy;
        #1;
        rdy = in_ready;
        acc = v && in_ready;
        if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                check("spurious_out", {out_valid, 15'd0, grad_x}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sig", {16'd0, sig}, {16'd0, e.sig});
                check("grad_x", {16'd0, grad_x}, {16'd0, e.gx});
                if (lat_chk) check("latency", cyc - e.cyc, 3);
            end
        end
        if (acc) exp_q.push_back('{esig, egx, cyc});
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        logic a, r;
        for (int i = 0; i < budget && exp_q.size() > 0; i++)
            tick(1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b1, a, r);
        check("drain_empty", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        tbl[14];
        logic        acc, rdy;
        logic [15:0] rx, rg, bx[6], bg[6];
        int          ni, first_out, out0;

        tbl[0]  = '{16'h0000, 16'h1000, 16'h0800, 16'h0800};
        tbl[1]  = '{16'h8000, 16'h1000, 16'h0000, 16'h0000};
        tbl[2]  = '{16'h7000, 16'hF000, 16'h1000, 16'hF000};
        tbl[3]  = '{16'h1800, 16'h2000, 16'h0D15, 16'h1A2A};
        tbl[4]  = '{16'hF400, 16'h1000, 16'h0575, 16'h0575};
        tbl[5]  = '{16'hA000, 16'h1000, 16'h000A, 16'h000A};
        tbl[6]  = '{16'h9FFF, 16'h1000, 16'h0000, 16'h0000};
        tbl[7]  = '{16'h5FFF, 16'h1000, 16'h0FF5, 16'h0FF5};
        tbl[8]  = '{16'h6000, 16'h1000, 16'h1000, 16'h1000};
        tbl[9]  = '{16'h7FFF, 16'h8000, 16'h1000, 16'h8000};
        tbl[10] = '{16'hFFFF, 16'hF000, 16'h07FF, 16'hF801};
        tbl[11] = '{16'h0000, 16'hFFFF, 16'h0800, 16'hFFFF};
        tbl[12] = '{16'h0C00, 16'h7FFF, 16'h0A8A, 16'h544F};
        tbl[13] = '{16'hF400, 16'hFFFF, 16'h0575, 16'hFFFF};

        rst = 1'b1; in_valid = 1'b0; x = '0; grad_y = '0; out_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_grad_x", {16'd0, grad_x}, 0);
        check("rst_sig", {16'd0, sig}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 1);

        // Table vectors back-to-back at full throughput
        lat_chk = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick(1'b1, tbl[i].x, tbl[i].gy, tbl[i].sig, tbl[i].gx, 1'b1, acc, rdy);
            check("tbl_accept", {31'd0, acc}, 1);
        end
        drain(20);
        lat_chk = 1'b0;

        // Random stream with random gaps and backpressure
        ni = 0;
        rx = 16'($urandom); rg = 16'($urandom);
        for (int t = 0; t < 400 && ni < 20; t++) begin
            tick($urandom_range(0, 3) != 0, rx, rg, sig_model(rx),
                 grad_model(rg, sig_model(rx)), $urandom_range(0, 3) != 0, acc, rdy);
            if (acc) begin
                ni++;
                rx = 16'($urandom); rg = 16'($urandom);
            end
        end
        check("rand_all_sent", ni, 20);
        drain(40);

        // Backpressure: 6 items, out_ready low for 5 cycles after the first output
        for (int i = 0; i < 6; i++) begin
            bx[i] = 16'($urandom); bg[i] = 16'($urandom);
        end
        ni = 0; first_out = -1; out0 = n_out;
        for (int t = 0; t < 60 && (ni < 6 || exp_q.size() > 0); t++) begin
            logic ordy;
            if (first_out < 0 && out_valid) first_out = t;
            ordy = !(first_out >= 0 && t > first_out && t <= first_out + 5);
            if (ni < 6)
                tick(1'b1, bx[ni], bg[ni], sig_model(bx[ni]),
                     grad_model(bg[ni], sig_model(bx[ni])), ordy, acc, rdy);
            else
                tick(1'b0, 16'd0, 16'd0, 16'd0, 16'd0, ordy, acc, rdy);
            if (!ordy) check("stall_in_ready", {31'd0, rdy}, 0);
            if (acc) ni++;
        end
        check("bp_first_out", first_out, 3);
        check("bp_sent", ni, 6);
        check("bp_out_count", n_out - out0, 6);
        drain(10);

        // Reset with 3 items in flight
        for (int i = 0; i < 3; i++) begin
            rx = 16'($urandom); rg = 16'($urandom);
            tick(1'b1, rx, rg, sig_model(rx), grad_model(rg, sig_model(rx)), 1'b1, acc, rdy);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 0);
        check("midrst_grad_x", {16'd0, grad_x}, 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("no_stale", {31'd0, out_valid}, 0);
            tick(1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b1, acc, rdy);
        end
        lat_chk = 1'b1;
        out0 = n_out;
        tick(1'b1, 16'h1800, 16'h2000, 16'h0D15, 16'h1A2A, 1'b1, acc, rdy);
        check("post_rst_accept", {31'd0, acc}, 1);
        drain(10);
        check("post_rst_out", n_out - out0, 1);
        lat_chk = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
